// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
//   NM_MAX  : largest supported master count
//   IDXW    : index width able to address NM_MAX masters
//   pick_t  : result of a request scan (index + found flag)
//   arb_case_e : classification of the request pattern seen by the current owner
package wb_arb_pkg;

   localparam int unsigned NM_MAX = 16;
   localparam int unsigned IDXW   = $clog2(NM_MAX);

   typedef struct packed {
      logic            found;
      logic [IDXW-1:0] idx;
   } pick_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SOLE,
      ARB_RELEASE,
      ARB_CONTEND
   } arb_case_e;

   // One-hot vector with bit idx set; empty when idx is outside the n masters.
   function automatic logic [NM_MAX-1:0] onehot(input logic [IDXW-1:0] idx,
                                                input int unsigned n);
      logic [NM_MAX-1:0] v;
      v = '0;
      if (32'(idx) < n) v[idx] = 1'b1;
      return v;
   endfunction

   // First set request scanning start, start+1, ... wrapping modulo n (not modulo 2^k).
   function automatic pick_t rr_pick(input logic [NM_MAX-1:0] req,
                                     input logic [IDXW-1:0]   start,
                                     input int unsigned       n);
      pick_t       r;
      int unsigned j;
      r = '0;
      for (int unsigned k = 0; k < NM_MAX; k++) begin
         j = 32'(start) + k;
         if (j >= n) j = j - n;
         if (k < n && !r.found && req[j[IDXW-1:0]]) begin
            r.found = 1'b1;
            r.idx   = IDXW'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational request picker.
//   req   : request vector with the current owner already masked out
//   start : first index to scan in round-robin mode (ignored when RR=0)
//   idx   : selected master
//   found : at least one bit of req is set
module wb_arb_pick
   import wb_arb_pkg::*;
#(
   parameter int unsigned NM   = 8,
   parameter int unsigned RR   = 1,
   parameter int unsigned GNTW = $clog2(NM)
) (
   input  logic [NM-1:0]   req,
   input  logic [GNTW-1:0] start,
   output logic [GNTW-1:0] idx,
   output logic            found
);

   // Fixed priority is a round-robin scan that always starts at master 0.
   always_comb begin
      pick_t p;
      p     = rr_pick(NM_MAX'(req), (RR != 0) ? IDXW'(start) : '0, NM);
      idx   = GNTW'(p.idx);
      found = p.found;
   end

endmodule

// File: rtl/wb_rr_arb.sv
// Parametrised Wishbone bus arbiter with fixed-priority or round-robin policy
// and an optional hold limit that preempts a streaming master at an ack.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : per-master cyc requests
//   ack_i        : ack of the granted transfer (transfer boundary)
//   lock_i       : granted master forbids preemption
//   gnt_o        : encoded grant (registered)
//   gnt_oh_o     : one-hot grant (registered)
//   gnt_valid_o  : granted master is requesting (combinational)
//   preempt_o    : last grant change was a forced preemption (registered pulse)
module wb_rr_arb
   import wb_arb_pkg::*;
#(
   parameter int unsigned NM       = 8,
   parameter int unsigned GNTW     = $clog2(NM),
   parameter int unsigned RR       = 1,
   parameter int unsigned MAX_HOLD = 0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NM-1:0]   req_i,
   input  logic            ack_i,
   input  logic            lock_i,
   output logic [GNTW-1:0] gnt_o,
   output logic [NM-1:0]   gnt_oh_o,
   output logic            gnt_valid_o,
   output logic            preempt_o
);

   localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   logic [HCW-1:0]    hold_q, hold_d;
   logic [GNTW-1:0]   gnt_d, start, pick_idx;
   logic [NM-1:0]     others, oh_d;
   logic [NM_MAX-1:0] oh_full;
   logic              cur_req, other, preempt_d;
   arb_case_e         cls;

   assign cur_req     = |(req_i & gnt_oh_o);
   assign others      = req_i & ~gnt_oh_o;
   assign gnt_valid_o = cur_req;
   assign start       = (gnt_o == GNTW'(NM - 1)) ? '0 : gnt_o + 1'b1;

   // With the owner masked, the same pick serves both release and preemption.
   wb_arb_pick #(.NM(NM), .RR(RR), .GNTW(GNTW)) u_pick (
      .req   (others),
      .start (start),
      .idx   (pick_idx),
      .found (other)
   );

   // Next grant, hold counter and preempt flag.
   always_comb begin
      gnt_d     = gnt_o;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      cls       = ARB_IDLE;
      if (cur_req && other)  cls = ARB_CONTEND;
      else if (cur_req)      cls = ARB_SOLE;
      else if (other)        cls = ARB_RELEASE;

      case (cls)
         ARB_RELEASE: begin
            gnt_d  = pick_idx;
            hold_d = '0;
         end
         ARB_CONTEND: begin
            if (MAX_HOLD != 0) begin
               // Counter saturates at the limit; preemption waits for an unlocked ack.
               if (hold_q < HOLD_LAST) begin
                  hold_d = hold_q + 1'b1;
               end else if (ack_i && !lock_i) begin
                  gnt_d     = pick_idx;
                  hold_d    = '0;
                  preempt_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      oh_full = onehot(IDXW'(gnt_d), NM);
      oh_d    = oh_full[NM-1:0];
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_o     <= '0;
         gnt_oh_o  <= NM'(1);
         hold_q    <= '0;
         preempt_o <= 1'b0;
      end else begin
         gnt_o     <= gnt_d;
         gnt_oh_o  <= oh_d;
         hold_q    <= hold_d;
         preempt_o <= preempt_d;
      end
   end

endmodule

// File: tb/tb_wb_rr_arb.sv
// Bench for wb_rr_arb: three configurations (legacy fixed, NM=5 RR, NM=4 RR)
// checked against constant vectors, directed sequences and a reference model.
module tb_wb_rr_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic       ack, lock;
   logic [7:0] req_a;
   logic [4:0] req_b;
   logic [3:0] req_c;
   logic [2:0] gnt_a, gnt_b;
   logic [1:0] gnt_c;
   logic [7:0] oh_a;
   logic [4:0] oh_b;
   logic [3:0] oh_c;
   logic       val_a, val_b, val_c, pre_a, pre_b, pre_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_rr_arb #(.NM(8), .RR(0), .MAX_HOLD(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .req_i(req_a), .ack_i(ack), .lock_i(lock),
      .gnt_o(gnt_a), .gnt_oh_o(oh_a), .gnt_valid_o(val_a), .preempt_o(pre_a));

   wb_rr_arb #(.NM(5), .RR(1), .MAX_HOLD(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(req_b), .ack_i(ack), .lock_i(lock),
      .gnt_o(gnt_b), .gnt_oh_o(oh_b), .gnt_valid_o(val_b), .preempt_o(pre_b));

   wb_rr_arb #(.NM(4), .RR(1), .MAX_HOLD(2)) dut_c (
      .clk_i(clk), .rst_i(rst), .req_i(req_c), .ack_i(ack), .lock_i(lock),
      .gnt_o(gnt_c), .gnt_oh_o(oh_c), .gnt_valid_o(val_c), .preempt_o(pre_c));

   // Reference model state, one slot per configuration.
   int P_NM [3] = '{8, 5, 4};
   int P_RR [3] = '{0, 1, 1};
   int P_MH [3] = '{0, 4, 2};
   int m_cur  [3];
   int m_hold [3];
   int m_pre  [3];

   task automatic chk(input string nm, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   // Next owner: RR scans the masters after the owner in circular order,
   // fixed takes the lowest-numbered requester other than the owner.
   function automatic int choose(input int d, input logic [15:0] req);
      int n;
      n = P_NM[d];
      if (P_RR[d] != 0) begin
         for (int k = 1; k < n; k++)
            if (req[(m_cur[d] + k) % n]) return (m_cur[d] + k) % n;
      end else begin
         for (int j = 0; j < n; j++)
            if (j != m_cur[d] && req[j]) return j;
      end
      return m_cur[d];
   endfunction

   task automatic model_step(input int d, input logic [15:0] req,
                             input bit a, input bit l, input bit r);
      bit others;
      if (r) begin
         m_cur[d] = 0; m_hold[d] = 0; m_pre[d] = 0;
         return;
      end
      m_pre[d] = 0;
      others = 1'b0;
      for (int j = 0; j < P_NM[d]; j++)
         if (j != m_cur[d] && req[j]) others = 1'b1;
      if (!others) return;
      if (!req[m_cur[d]]) begin
         m_cur[d] = choose(d, req);
         m_hold[d] = 0;
      end else if (P_MH[d] > 0) begin
         if (m_hold[d] < P_MH[d] - 1) m_hold[d]++;
         else if (a && !l) begin
            m_cur[d] = choose(d, req);
            m_hold[d] = 0;
            m_pre[d] = 1;
         end
      end
   endtask

   // One clock: sample #1 after the edge, advance the model, compare everything.
   task automatic tick();
      @(posedge clk);
      #1;
      model_step(0, 16'(req_a), ack, lock, rst);
      model_step(1, 16'(req_b), ack, lock, rst);
      model_step(2, 16'(req_c), ack, lock, rst);
      chk("a_gnt", int'(gnt_a), m_cur[0]);
      chk("a_oh",  int'(oh_a), 1 << m_cur[0]);
      chk("a_val", int'(val_a), int'(req_a[m_cur[0]]));
      chk("a_pre", int'(pre_a), m_pre[0]);
      chk("b_gnt", int'(gnt_b), m_cur[1]);
      chk("b_oh",  int'(oh_b), 1 << m_cur[1]);
      chk("b_val", int'(val_b), int'(req_b[m_cur[1]]));
      chk("b_pre", int'(pre_b), m_pre[1]);
      chk("c_gnt", int'(gnt_c), m_cur[2]);
      chk("c_oh",  int'(oh_c), 1 << m_cur[2]);
      chk("c_val", int'(val_c), int'(req_c[m_cur[2]]));
      chk("c_pre", int'(pre_c), m_pre[2]);
   endtask

   typedef struct {
      logic       rst;
      logic [7:0] req;
      int         gnt;
   } vec_t;

   vec_t vt [16];

   initial begin
      // Legacy sticky fixed-priority vectors (NM=8, RR=0, MAX_HOLD=0).
      vt[0]  = '{1'b1, 8'h00, 0};
      vt[1]  = '{1'b1, 8'h00, 0};
      vt[2]  = '{1'b0, 8'h00, 0};
      vt[3]  = '{1'b0, 8'h0A, 1};
      vt[4]  = '{1'b0, 8'h0A, 1};
      vt[5]  = '{1'b0, 8'h0A, 1};
      vt[6]  = '{1'b0, 8'h08, 3};
      vt[7]  = '{1'b0, 8'h09, 3};
      vt[8]  = '{1'b0, 8'h01, 0};
      vt[9]  = '{1'b0, 8'h00, 0};
      vt[10] = '{1'b0, 8'h80, 7};
      vt[11] = '{1'b0, 8'hFF, 7};
      vt[12] = '{1'b0, 8'h7F, 0};
      vt[13] = '{1'b0, 8'h06, 1};
      vt[14] = '{1'b1, 8'h06, 0};
      vt[15] = '{1'b0, 8'h06, 1};

      for (int d = 0; d < 3; d++) begin
         m_cur[d] = 0; m_hold[d] = 0; m_pre[d] = 0;
      end
      rst = 1'b1; ack = 1'b0; lock = 1'b0;
      req_a = '0; req_b = '0; req_c = '0;

      // Reset then idle parking.
      tick(); tick();
      chk("rst_gnt", int'(gnt_a), 0);
      chk("rst_oh",  int'(oh_a), 8'h01);
      chk("rst_pre", int'(pre_a), 0);
      chk("rst_oh_b", int'(oh_b), 1);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_gnt", int'(gnt_a), 0);
      end

      // Constant vector table on the legacy configuration.
      ack = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rst = vt[i].rst; req_a = vt[i].req;
         tick();
         chk("tbl_gnt", int'(gnt_a), vt[i].gnt);
         chk("tbl_oh",  int'(oh_a), 1 << vt[i].gnt);
         chk("tbl_pre", int'(pre_a), 0);
      end

      // Round-robin fairness: NM=5, MAX_HOLD=4, all requesting, ack every cycle.
      rst = 1'b1; req_b = 5'h1F; ack = 1'b1; lock = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         chk("rr_gnt", int'(gnt_b), (k / 4) % 5);
         chk("rr_pre", int'(pre_b), (k % 4 == 0) ? 1 : 0);
      end

      // Lock holds off preemption of master 2.
      rst = 1'b1; req_c = 4'h0;
      tick();
      rst = 1'b0; req_c = 4'h4; ack = 1'b1;
      tick();
      chk("lock_setup", int'(gnt_c), 2);
      req_c = 4'hF; lock = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("lock_hold", int'(gnt_c), 2);
         chk("lock_pre",  int'(pre_c), 0);
      end
      lock = 1'b0;
      tick();
      chk("unlock_gnt", int'(gnt_c), 3);
      chk("unlock_pre", int'(pre_c), 1);

      // Expired hold waits for a transfer boundary.
      ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bnd_wait", int'(gnt_c), 3);
      end
      ack = 1'b1;
      tick();
      chk("bnd_gnt", int'(gnt_c), 0);
      chk("bnd_pre", int'(pre_c), 1);

      // Reset in the middle of contention.
      rst = 1'b1;
      tick();
      rst = 1'b0; req_a = 8'h20; req_c = 4'hF; ack = 1'b0;
      tick();
      chk("mid_setup", int'(gnt_a), 5);
      req_a = 8'h21;
      tick(); tick();
      chk("mid_cont", int'(gnt_a), 5);
      rst = 1'b1;
      tick();
      chk("mid_rst_a", int'(gnt_a), 0);
      chk("mid_rst_c", int'(gnt_c), 0);
      rst = 1'b0; ack = 1'b1;
      tick();
      chk("mid_sticky", int'(gnt_a), 0);
      chk("mid_hold_clr", int'(gnt_c), 0);
      tick();
      chk("mid_c_pre_gnt", int'(gnt_c), 1);
      chk("mid_c_pre", int'(pre_c), 1);
      req_a = 8'h20;
      tick();
      chk("mid_resume", int'(gnt_a), 5);

      // Randomised traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         ack   = $urandom_range(0, 1) == 1;
         lock  = ($urandom_range(0, 7) == 0);
         req_a = 8'($urandom) & 8'($urandom);
         req_b = 5'($urandom) | 5'($urandom);
         req_c = 4'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
